spi_reg_master: RTL

- SPI initiator (mode 0, MSB first) that runs single-register read/write transactions against the on-chip SPI register slave.
- Used by the bench, and by a future on-chip sequencer, to load P/E/M/Const, pulse Start, poll Status and read C.
- Takes a parallel request, serialises a command byte plus a data byte, and returns read data on a one-cycle done pulse.

---
 rtl/spi_reg_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for single-register read/write frames: one command byte
// {rw, zeros, addr} followed by one data byte, MSB first, with a late MISO sample.
module spi_reg_master #(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [REG_W-1:0]  wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [REG_W-1:0]  rdata_o,
    output logic              sclk_o,
    output logic              nss_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int FRAME_W = 2 * REG_W;
    localparam int BIT_W   = $clog2(FRAME_W) + 1;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   tx_q;
    logic [REG_W-1:0]     rx_q;
    logic [BIT_W-1:0]     bit_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_read_q;
    logic                 busy_q;
    logic                 done_q;
    logic [REG_W-1:0]     rdata_q;
    logic                 sclk_q;
    logic                 nss_q;
    logic                 mosi_q;

    logic [REG_W-1:0]     cmd_word;
    logic [FRAME_W-1:0]   frame_word;

    always_comb begin
        cmd_word                = '0;
        cmd_word[REG_W-1]       = rw_i;
        cmd_word[ADDR_W-1:0]    = addr_i;
        frame_word              = {cmd_word, (rw_i ? wdata_i : {REG_W{1'b0}})};
    end

    logic div_last;
    logic gap_last;
    logic bit_last;
    assign div_last = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign gap_last = (cnt_q == CNT_W'(CS_GAP - 1));
    assign bit_last = (bit_q == BIT_W'(FRAME_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            sclk_q    <= 1'b0;
            nss_q     <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        tx_q      <= frame_word;
                        is_read_q <= ~rw_i;
                        mosi_q    <= frame_word[FRAME_W-1];
                        nss_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        // Sampling at the end of the high phase gives the slave
                        // almost a full half-period to settle MISO.
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        rx_q   <= {rx_q[REG_W-2:0], miso_i};
                        if (bit_last) begin
                            state_q <= HOLD;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= tx_q << 1;
                            mosi_q  <= tx_q[FRAME_W-2];
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        cnt_q   <= '0;
                        nss_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= GAP;
                        if (is_read_q) begin
                            rdata_q <= rx_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign sclk_o  = sclk_q;
    assign nss_o   = nss_q;
    assign mosi_o  = mosi_q;

endmodule
